// File: rtl/psum_mem_ctrl_pkg.sv
// Shared types and constants for the partial-sum memory controller.
package psum_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int unsigned DEPTH_LOG2_DEF = 10;
    localparam int unsigned MEM_DELAY_MIN  = 1;
    localparam int unsigned MEM_DELAY_MAX  = 4;
    // Wide enough for reads in flight plus FIFO words at the largest delay.
    localparam int unsigned OCC_W          = $clog2(2 * MEM_DELAY_MAX + 2);

endpackage

// File: rtl/psum_drain_fifo.sv
// Small synchronous FIFO buffering drain words that arrive while the stream is stalled.
module psum_drain_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dat,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dat     = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/psum_mem_ctrl.sv
// Partial-sum buffer: fixed-latency coherent read port, write-back port,
// sequential clear engine and credit-limited valid/ready drain stream.
module psum_mem_ctrl
    import psum_mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int unsigned MEM_DELAY  = 1,
    parameter int unsigned REG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] memctrl0_wadd,
    input  logic                  memctrl0_wren,
    input  logic [DATA_WIDTH-1:0] memctrl0_idat,
    input  logic [ADDR_WIDTH-1:0] memctrl0_radd,
    input  logic                  memctrl0_rden,
    output logic [DATA_WIDTH-1:0] memctrl0_odat,
    output logic                  memctrl0_oval,
    input  logic                  i_clear,
    input  logic                  i_drain_start,
    input  logic [REG_WIDTH-1:0]  i_drain_len,
    output logic [DATA_WIDTH-1:0] m_dat,
    output logic                  m_vld,
    input  logic                  m_rdy,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int unsigned DLY = (MEM_DELAY < MEM_DELAY_MIN) ? MEM_DELAY_MIN :
                                  (MEM_DELAY > MEM_DELAY_MAX) ? MEM_DELAY_MAX : MEM_DELAY;
    localparam int unsigned WORDS      = 2 ** DEPTH_LOG2;
    localparam int unsigned FIFO_DEPTH = DLY + 1;

    typedef logic [DEPTH_LOG2-1:0] addr_t;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    state_t                state;
    addr_t                 clr_addr;
    logic [REG_WIDTH-1:0]  len_q;
    logic [REG_WIDTH-1:0]  issue_cnt;
    logic [REG_WIDTH-1:0]  left;

    logic [DATA_WIDTH-1:0] stg_dat  [DLY];
    addr_t                 stg_addr [DLY];
    logic [DLY-1:0]        stg_acc;
    logic [DLY-1:0]        stg_drn;

    logic                  we;
    addr_t                 wa;
    logic [DATA_WIDTH-1:0] wd;
    addr_t                 ra;
    logic                  re;
    logic                  drain_issue;
    logic                  hs;
    logic                  err_evt;
    logic [OCC_W-1:0]      inflight;
    logic [OCC_W-1:0]      occ;

    logic [DATA_WIDTH-1:0] fifo_dat;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [OCC_W-1:0]      fifo_cnt;
    logic                  last_drn;
    logic                  unused_bits;

    assign unused_bits = ^{memctrl0_wadd[ADDR_WIDTH-1:DEPTH_LOG2],
                           memctrl0_radd[ADDR_WIDTH-1:DEPTH_LOG2], fifo_full};

    // Clear owns the single write port; accumulator writes are dropped meanwhile.
    assign we = (state == ST_CLEAR) || memctrl0_wren;
    assign wa = (state == ST_CLEAR) ? clr_addr : memctrl0_wadd[DEPTH_LOG2-1:0];
    assign wd = (state == ST_CLEAR) ? '0 : memctrl0_idat;

    assign ra = memctrl0_rden ? memctrl0_radd[DEPTH_LOG2-1:0] : issue_cnt[DEPTH_LOG2-1:0];
    assign re = memctrl0_rden || drain_issue;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < DLY; k++) inflight = inflight + OCC_W'(stg_drn[k]);
    end

    // A word leaving this cycle frees its credit for a read issued now.
    assign occ         = inflight + fifo_cnt - OCC_W'(hs);
    assign drain_issue = (state == ST_DRAIN) && !memctrl0_rden &&
                         (issue_cnt < len_q) && (occ < OCC_W'(FIFO_DEPTH));

    assign err_evt = ((state == ST_CLEAR) && (memctrl0_rden || memctrl0_wren)) ||
                     ((state != ST_IDLE) && (i_clear || i_drain_start)) ||
                     ((state == ST_IDLE) && i_clear && i_drain_start);

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    // Read pipeline; each stage picks up any write to its address while in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_acc <= '0;
            stg_drn <= '0;
            for (int k = 0; k < DLY; k++) begin
                stg_dat[k]  <= '0;
                stg_addr[k] <= '0;
            end
        end else begin
            stg_acc[0]  <= memctrl0_rden;
            stg_drn[0]  <= drain_issue;
            stg_addr[0] <= ra;
            if (re) stg_dat[0] <= (we && (wa == ra)) ? wd : mem[ra];
            for (int k = 1; k < DLY; k++) begin
                stg_acc[k]  <= stg_acc[k-1];
                stg_drn[k]  <= stg_drn[k-1];
                stg_addr[k] <= stg_addr[k-1];
                stg_dat[k]  <= (we && (wa == stg_addr[k-1])) ? wd : stg_dat[k-1];
            end
        end
    end

    assign memctrl0_oval = stg_acc[DLY-1];
    assign memctrl0_odat = stg_dat[DLY-1];

    // Fresh drain word bypasses the FIFO when nothing older is queued.
    assign last_drn = stg_drn[DLY-1];
    assign m_vld    = !fifo_empty || last_drn;
    assign m_dat    = fifo_empty ? stg_dat[DLY-1] : fifo_dat;
    assign hs       = m_vld && m_rdy;

    psum_drain_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .CNT_W      (OCC_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (last_drn && !(fifo_empty && m_rdy)),
        .push_dat (stg_dat[DLY-1]),
        .pop      (!fifo_empty && m_rdy),
        .dat      (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    // Control FSM with registered busy/error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
            clr_addr  <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
            left      <= '0;
        end else begin
            if (err_evt) o_err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (i_clear) begin
                        state    <= ST_CLEAR;
                        o_busy   <= 1'b1;
                        clr_addr <= '0;
                    end else if (i_drain_start && (i_drain_len != '0)) begin
                        state     <= ST_DRAIN;
                        o_busy    <= 1'b1;
                        len_q     <= i_drain_len;
                        left      <= i_drain_len;
                        issue_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    clr_addr <= clr_addr + DEPTH_LOG2'(1);
                    if (clr_addr == '1) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_issue) issue_cnt <= issue_cnt + REG_WIDTH'(1);
                    if (hs) begin
                        left <= left - REG_WIDTH'(1);
                        if (left == REG_WIDTH'(1)) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_mem_ctrl.sv
// Scoreboard bench for psum_mem_ctrl: accumulator reads and drain words are
// predicted from a reference memory model and compared as the DUT emits them.
module tb_psum_mem_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DL    = 10;
    localparam int unsigned MD    = 2;
    localparam int unsigned RW    = 32;
    localparam int unsigned WORDS = 1 << DL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] wadd = '0;
    logic          wren = 1'b0;
    logic [DW-1:0] idat = '0;
    logic [AW-1:0] radd = '0;
    logic          rden = 1'b0;
    logic [DW-1:0] odat;
    logic          oval;
    logic          i_clear = 1'b0;
    logic          i_drain_start = 1'b0;
    logic [RW-1:0] i_drain_len = '0;
    logic [DW-1:0] m_dat;
    logic          m_vld;
    logic          m_rdy = 1'b0;
    logic          o_busy;
    logic          o_err;

    psum_mem_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH_LOG2 (DL),
        .MEM_DELAY  (MD),
        .REG_WIDTH  (RW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .memctrl0_wadd (wadd),
        .memctrl0_wren (wren),
        .memctrl0_idat (idat),
        .memctrl0_radd (radd),
        .memctrl0_rden (rden),
        .memctrl0_odat (odat),
        .memctrl0_oval (oval),
        .i_clear       (i_clear),
        .i_drain_start (i_drain_start),
        .i_drain_len   (i_drain_len),
        .m_dat         (m_dat),
        .m_vld         (m_vld),
        .m_rdy         (m_rdy),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    int            cyc = 0;
    int            n_chk = 0;
    int            n_err = 0;
    int            hs_cnt = 0;
    int            last_hs_cyc = 0;
    int            rdy_mode = 0;
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_dat = '0;
    logic [DW-1:0] model [WORDS];

    logic [DL-1:0] q_addr [$];
    logic [DW-1:0] q_dat  [$];
    int            q_due  [$];
    logic [DW-1:0] drn_q  [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_rdy = 1'b1;
            1:       m_rdy = ~m_rdy;
            default: m_rdy = 1'b0;
        endcase
    end

    // Accumulator read monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (oval) begin
                if (q_dat.size() == 0) check("oval_spurious", 1, 0);
                else begin
                    check("odat", odat, q_dat.pop_front());
                    check("rd_latency", 32'(cyc), 32'(q_due.pop_front()));
                    void'(q_addr.pop_front());
                end
            end else if (q_due.size() != 0 && q_due[0] <= cyc) begin
                check("oval_missing", 0, 1);
                void'(q_dat.pop_front());
                void'(q_due.pop_front());
                void'(q_addr.pop_front());
            end
        end
    end

    // Drain stream monitor.
    always @(negedge clk) begin
        if (rst) hold_pend = 1'b0;
        else begin
            if (hold_pend) begin
                check("hold_vld", 32'(m_vld), 1);
                check("hold_dat", m_dat, hold_dat);
            end
            hold_pend = m_vld && !m_rdy;
            hold_dat  = m_dat;
            if (m_vld && m_rdy) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (drn_q.size() == 0) check("drain_spurious", 1, 0);
                else check("m_dat", m_dat, drn_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rden = 1'b0;
        wren = 1'b0;
        i_clear = 1'b0;
        i_drain_start = 1'b0;
    endtask

    task automatic acc_cycle(input logic rd, input int ra, input logic wr, input int wa,
                             input logic [DW-1:0] wd);
        rden = rd;
        radd = AW'(ra);
        wren = wr;
        wadd = AW'(wa);
        idat = wd;
        if (wr) begin
            for (int i = 0; i < q_due.size(); i++)
                if (q_addr[i] == DL'(wa) && q_due[i] > cyc) q_dat[i] = wd;
            model[DL'(wa)] = wd;
        end
        if (rd) begin
            q_addr.push_back(DL'(ra));
            q_dat.push_back(model[DL'(ra)]);
            q_due.push_back(cyc + int'(MD));
        end
        tick();
    endtask

    task automatic drain_start(input int len);
        for (int i = 0; i < len; i++) drn_q.push_back(model[DL'(i)]);
        i_drain_start = 1'b1;
        i_drain_len   = RW'(len);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (drn_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 32'(drn_q.size()), 0);
    endtask

    initial begin
        int s;
        int busy_cycles;
        int hs_snap;

        for (int i = 0; i < int'(WORDS); i++) model[i] = '0;
        repeat (3) tick();
        check("rst_odat", odat, 0);
        check("rst_oval", 32'(oval), 0);
        check("rst_m_dat", m_dat, 0);
        check("rst_m_vld", 32'(m_vld), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_err", 32'(o_err), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) acc_cycle(0, 0, 1, i, DW'(i) * 32'h0101_0101);
        acc_cycle(0, 0, 1, 5, 32'h0403_0201);
        acc_cycle(1, 5, 0, 0, 0);
        acc_cycle(1, 9, 1, 9, 32'hDEAD_BEEF);
        acc_cycle(1, 11, 1, 10, 32'hCAFE_0010);
        acc_cycle(1, 10, 0, 0, 0);
        acc_cycle(0, 0, 1, 7, 32'h0000_0011);
        tick();
        acc_cycle(1, 7, 0, 0, 0);
        acc_cycle(0, 0, 1, 7, 32'h0000_00AA);
        acc_cycle(0, 0, 1, 7, 32'h0000_00BB);
        acc_cycle(1, 7, 0, 0, 0);
        for (int i = 0; i < 40; i++)
            acc_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom());
        repeat (MD + 2) tick();
        check("acc_q_empty", 32'(q_dat.size()), 0);

        for (int i = 0; i < 8; i++) acc_cycle(0, 0, 1, i, DW'(i) * 32'h0101_0101);
        rdy_mode = 1;
        drain_start(8);
        tick();
        check("drain_busy_rise", 32'(o_busy), 1);
        wait_drain(100);
        check("drain_busy_fall", 32'(o_busy), 0);

        rdy_mode = 0;
        tick();
        s = cyc;
        drain_start(8);
        tick();
        wait_drain(100);
        check("drain_thruput", 32'(last_hs_cyc), 32'(s + 8 + int'(MD)));

        i_drain_start = 1'b1;
        i_drain_len   = '0;
        tick();
        check("len0_idle", 32'(o_busy), 0);

        hs_snap = hs_cnt;
        drain_start(8);
        for (int i = 0; i < 10; i++) acc_cycle(1, i + 3, 0, 0, 0);
        check("drain_stalled", 32'(hs_cnt), 32'(hs_snap));
        wait_drain(100);
        check("stall_busy_fall", 32'(o_busy), 0);

        acc_cycle(0, 0, 1, 512, 32'h1234_5678);
        acc_cycle(0, 0, 1, 1023, 32'h8765_4321);
        i_clear = 1'b1;
        tick();
        busy_cycles = 0;
        while (o_busy && busy_cycles < 1100) begin
            busy_cycles++;
            tick();
        end
        check("clear_busy_len", 32'(busy_cycles), 32'(WORDS));
        for (int i = 0; i < int'(WORDS); i++) model[i] = '0;
        acc_cycle(1, 0, 0, 0, 0);
        acc_cycle(1, 512, 0, 0, 0);
        acc_cycle(1, 1023, 0, 0, 0);
        repeat (MD + 2) tick();
        check("err_clean", 32'(o_err), 0);

        i_clear = 1'b1;
        tick();
        i_drain_start = 1'b1;
        i_drain_len   = RW'(4);
        tick();
        check("err_start_in_clear", 32'(o_err), 1);
        busy_cycles = 0;
        while (o_busy && busy_cycles < 1100) begin
            busy_cycles++;
            tick();
        end
        check("clear2_done", 32'(o_busy), 0);

        rdy_mode = 2;
        drain_start(8);
        tick();
        repeat (6) tick();
        check("vld_before_rst", 32'(m_vld), 1);
        rst = 1'b1;
        q_addr.delete();
        q_dat.delete();
        q_due.delete();
        drn_q.delete();
        tick();
        check("rst_drop_vld", 32'(m_vld), 0);
        check("rst_drop_busy", 32'(o_busy), 0);
        check("rst_drop_err", 32'(o_err), 0);
        rst = 1'b0;
        rdy_mode = 0;
        repeat (5) tick();
        check("vld_after_rst", 32'(m_vld), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
